pr_sref_ctrl_slave: RTL and testbench
=====================================

# pr_sref_ctrl_slave

AXI4-Lite register responder in the PR region, terminating the shell's `M_AXI_LITE_TO_HLS_PR_NORTH` master. It converts host register writes into per-channel DDR4 self-refresh entry/exit handshakes on the shell's `C0/C2/C3_DDR_SREF_CTRL_IN` buses and monitors the matching `_OUT` buses. It reports channel state, calibration status and timeout errors back to the host.

## Interface

Parameters:
- `ADDR_W`, 12: AXI-Lite address width.
- `TIMEOUT_W`, 24: timeout counter and register width.
- `TIMEOUT_DEF`, 24'd250000: reset value of the TIMEOUT register (1 ms at 250 MHz).

Ports (the `S_AXI_LITE_*` prefix covers all AXI-Lite signals):
- `clk_250M` in 1: sole clock. The same clock drives the shell AXI-Lite master and the SREF buses.
- `rst_250M` in 1: synchronous, active-high reset.
- `S_AXI_LITE_awaddr` in ADDR_W, `awprot` in 3 (ignored), `awvalid` in 1, `awready` out 1.
- `S_AXI_LITE_wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1.
- `S_AXI_LITE_bresp` out 2, `bvalid` out 1, `bready` in 1.
- `S_AXI_LITE_araddr` in ADDR_W, `arprot` in 3 (ignored), `arvalid` in 1, `arready` out 1.
- `S_AXI_LITE_rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1.
- `C0_DDR_SREF_CTRL_IN`, `C2_DDR_SREF_CTRL_IN`, `C3_DDR_SREF_CTRL_IN` out 8 each: driven toward the shell. Bit0 is the self-refresh request level; bits[7:1] are always 0.
- `C0_DDR_SREF_CTRL_OUT`, `C2_DDR_SREF_CTRL_OUT`, `C3_DDR_SREF_CTRL_OUT` in 8 each: from the shell. Bit0 is the self-refresh ack (1 = in self-refresh); bit1 is calib_complete; other bits are ignored.

## Operation

Register map (decode uses `addr[ADDR_W-1:2]`; `wstrb` is honoured per byte):
- 0x00 CTRL, RW.
  - Bits[2:0]: target state for C0, C2, C3 (1 = self-refresh).
  - Bit8: write 1 to clear error bits; self-clearing, reads 0.
- 0x04 STATUS, RO.
  - Bits[1:0], [3:2], [5:4]: FSM state of C0, C2, C3.
  - Bits[10:8]: sticky timeout error per channel.
  - Bits[18:16]: synchronized calib_complete per channel.
- 0x08 TIMEOUT, RW, bits[TIMEOUT_W-1:0]. A value of 0 disables the timeout.
- 0x0C ID, RO, 32'h53524546.
- Unmapped addresses: writes are dropped with bresp=2'b10 (SLVERR); reads return rdata=0 with rresp=2'b10. Mapped accesses return OKAY (2'b00).

AXI-Lite write path:
- AW and W are accepted independently; each is latched into a one-entry holding register.
- `awready` is 1 while the AW holder is empty and `bvalid` is 0. `wready` follows the same rule for the W holder.
- When both holders are full, the register write commits and `bvalid` asserts in the same cycle. Both holders then clear.
- `bvalid` holds until `bready`.

AXI-Lite read path:
- `arready` is 1 while `rvalid` is 0.
- On AR acceptance, `rdata`, `rresp` and `rvalid` register on the next edge and hold until `rready`.
- Reads and writes proceed concurrently. A read in the same cycle as a write commit returns the pre-write value.

Per-channel FSM (three identical instances; `ack` and `calib` pass through 2-flop synchronizers first):
- ACTIVE (0): `req`=0. If target=1, clear the counter and go to ENTERING.
- ENTERING (1): `req`=1, counter increments.
  - `ack`=1: go to IN_SREF.
  - Counter reaches TIMEOUT (TIMEOUT≠0): set error and go to EXITING.
- IN_SREF (2): `req`=1. If target=0, clear the counter and go to EXITING.
- EXITING (3): `req`=0, counter increments.
  - `ack`=0: go to ACTIVE.
  - Timeout: set error and go to ACTIVE.
- Target changes during ENTERING or EXITING are held in CTRL and acted on once the FSM reaches a stable state.
- A channel that timed out in ENTERING retries from ACTIVE if target is still 1.
- The counter saturates at all-ones.

## Timing

- Reset values:
  - All `*ready`, `bvalid` and `rvalid` are 0 during reset. Ready signals go to 1 on the first cycle after reset.
  - `bresp`, `rresp` and `rdata` are 0; all `_CTRL_IN` are 8'h00.
  - CTRL=0; errors=0; TIMEOUT=TIMEOUT_DEF; all FSMs are in ACTIVE; synchronizers are 0.
- Reset mid-handshake abandons the transaction and drops `req` to 0 within one cycle.
- Write latency: with AW and W arriving in the same cycle, `bvalid` asserts on the next edge. The new CTRL value is visible to the FSM on that same edge.
- Request latency: `req` asserts 1 cycle after the CTRL commit.
- Ack latency: an `ack` change is seen by the FSM 2 cycles after the pin changes, and the state update follows 1 cycle later.
- Read latency: 1 cycle from the AR handshake to `rvalid`.
- Timeout fires when the counter equals TIMEOUT. The error bit sets on the same edge as the state change.
- Error clear and a new timeout in the same cycle: the set wins.

## Test plan

- Reset, then read 0x0C → rdata=32'h53524546, rresp=0. Read 0x08 → 250000.
- Write CTRL=0x1 (AW and W on the same cycle) → bvalid next cycle. `C0_DDR_SREF_CTRL_IN`=8'h01 one cycle later. Drive ack=1 → STATUS[1:0]=2 after 3 cycles.
- From IN_SREF, write CTRL=0x0 → `req` falls to 0 and STATUS[1:0]=3. Drive ack=0 → STATUS[1:0]=0.
- Write TIMEOUT=16, then CTRL=0x2 with ack held at 0 → after 16 cycles in ENTERING, STATUS bit9=1 and C2 passes through EXITING. Write 0x100 → bit9 clears.
- AW valid 5 cycles before W, with bready held low 4 cycles → exactly one `bvalid` pulse, and `awready` stays 0 until B completes.
- Write and read to 0x40 → bresp=2'b10, rresp=2'b10, rdata=0. Assert reset during ENTERING → all `_CTRL_IN`=0 on the next cycle.

Source files
------------

// File: rtl/pr_sref_ctrl_slave.sv
// AXI4-Lite register slave driving DDR4 self-refresh request handshakes for
// three memory channels (C0, C2, C3) and reporting their state and errors.
module pr_sref_ctrl_slave #(
  parameter int                   ADDR_W      = 12,
  parameter int                   TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_DEF = 24'd250000
) (
  input  logic              clk_250M,
  input  logic              rst_250M,
  input  logic [ADDR_W-1:0] S_AXI_LITE_awaddr,
  input  logic [2:0]        S_AXI_LITE_awprot,
  input  logic              S_AXI_LITE_awvalid,
  output logic              S_AXI_LITE_awready,
  input  logic [31:0]       S_AXI_LITE_wdata,
  input  logic [3:0]        S_AXI_LITE_wstrb,
  input  logic              S_AXI_LITE_wvalid,
  output logic              S_AXI_LITE_wready,
  output logic [1:0]        S_AXI_LITE_bresp,
  output logic              S_AXI_LITE_bvalid,
  input  logic              S_AXI_LITE_bready,
  input  logic [ADDR_W-1:0] S_AXI_LITE_araddr,
  input  logic [2:0]        S_AXI_LITE_arprot,
  input  logic              S_AXI_LITE_arvalid,
  output logic              S_AXI_LITE_arready,
  output logic [31:0]       S_AXI_LITE_rdata,
  output logic [1:0]        S_AXI_LITE_rresp,
  output logic              S_AXI_LITE_rvalid,
  input  logic              S_AXI_LITE_rready,
  output logic [7:0]        C0_DDR_SREF_CTRL_IN,
  output logic [7:0]        C2_DDR_SREF_CTRL_IN,
  output logic [7:0]        C3_DDR_SREF_CTRL_IN,
  input  logic [7:0]        C0_DDR_SREF_CTRL_OUT,
  input  logic [7:0]        C2_DDR_SREF_CTRL_OUT,
  input  logic [7:0]        C3_DDR_SREF_CTRL_OUT
);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_ENTERING = 2'd1,
    ST_IN_SREF  = 2'd2,
    ST_EXITING  = 2'd3
  } ch_state_t;

  localparam logic [ADDR_W-3:0] A_CTRL    = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] A_STATUS  = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] A_TIMEOUT = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] A_ID      = (ADDR_W-2)'(3);

  // Handshake rule on every channel: a beat transfers on a rising clk edge
  // where valid and ready are both 1; valid never drops before that edge.
  logic              aw_full, w_full, bvalid_q, rvalid_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q, rdata_q, rd_word;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q, rresp_q, rd_resp;
  logic [2:0]        target_q, err_q, err_set, tmo_hit, req;
  logic [2:0]        ack_m, ack_s, cal_m, cal_s;
  logic [TIMEOUT_W-1:0] timeout_q;
  ch_state_t            state_q [3];
  ch_state_t            state_d [3];
  logic [TIMEOUT_W-1:0] cnt_q [3];
  logic [TIMEOUT_W-1:0] cnt_d [3];

  logic              aw_hs, w_hs, commit, err_clr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-3:0] wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              unused;

  assign S_AXI_LITE_awready = !rst_250M && !aw_full && !bvalid_q;
  assign S_AXI_LITE_wready  = !rst_250M && !w_full && !bvalid_q;
  assign S_AXI_LITE_arready = !rst_250M && !rvalid_q;
  assign S_AXI_LITE_bvalid  = bvalid_q;
  assign S_AXI_LITE_bresp   = bresp_q;
  assign S_AXI_LITE_rvalid  = rvalid_q;
  assign S_AXI_LITE_rdata   = rdata_q;
  assign S_AXI_LITE_rresp   = rresp_q;

  assign aw_hs   = S_AXI_LITE_awvalid && S_AXI_LITE_awready;
  assign w_hs    = S_AXI_LITE_wvalid && S_AXI_LITE_wready;
  // Commit on the edge the second half arrives, so same-cycle AW+W costs one cycle.
  assign commit  = (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_addr = aw_full ? aw_addr_q : S_AXI_LITE_awaddr;
  assign wr_data = w_full ? w_data_q : S_AXI_LITE_wdata;
  assign wr_strb = w_full ? w_strb_q : S_AXI_LITE_wstrb;
  assign wr_idx  = wr_addr[ADDR_W-1:2];
  assign err_clr = commit && (wr_idx == A_CTRL) && wr_strb[1] && wr_data[8];

  assign unused = ^{S_AXI_LITE_awprot, S_AXI_LITE_arprot, S_AXI_LITE_araddr[1:0],
                    wr_addr[1:0], wr_data, C0_DDR_SREF_CTRL_OUT[7:2],
                    C2_DDR_SREF_CTRL_OUT[7:2], C3_DDR_SREF_CTRL_OUT[7:2]};

  always_comb begin
    rd_word = 32'h0;
    rd_resp = 2'b00;
    case (S_AXI_LITE_araddr[ADDR_W-1:2])
      A_CTRL:    rd_word = {29'h0, target_q};
      A_STATUS:  rd_word = {13'h0, cal_s, 5'h0, err_q, 2'b00,
                            state_q[2], state_q[1], state_q[0]};
      A_TIMEOUT: rd_word = 32'(timeout_q);
      A_ID:      rd_word = 32'h53524546;
      default:   rd_resp = 2'b10;
    endcase
  end

  always_ff @(posedge clk_250M) begin
    if (rst_250M) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      target_q  <= 3'b000;
      timeout_q <= TIMEOUT_DEF;
      err_q     <= 3'b000;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_idx <= A_ID) ? 2'b00 : 2'b10;
        if (wr_idx == A_CTRL && wr_strb[0]) target_q <= wr_data[2:0];
        if (wr_idx == A_TIMEOUT) begin
          for (int b = 0; b < TIMEOUT_W; b++)
            if (wr_strb[b/8]) timeout_q[b] <= wr_data[b];
        end
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= S_AXI_LITE_awaddr;
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= S_AXI_LITE_wdata;
          w_strb_q <= S_AXI_LITE_wstrb;
        end
        if (bvalid_q && S_AXI_LITE_bready) bvalid_q <= 1'b0;
      end
      // A timeout landing on the same edge as a clear stays set.
      err_q <= (err_q & ~{3{err_clr}}) | err_set;
      if (S_AXI_LITE_arvalid && S_AXI_LITE_arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && S_AXI_LITE_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_250M) begin
    if (rst_250M) begin
      ack_m <= 3'b000;
      ack_s <= 3'b000;
      cal_m <= 3'b000;
      cal_s <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_ACTIVE;
        cnt_q[i]   <= '0;
      end
    end else begin
      ack_m <= {C3_DDR_SREF_CTRL_OUT[0], C2_DDR_SREF_CTRL_OUT[0], C0_DDR_SREF_CTRL_OUT[0]};
      ack_s <= ack_m;
      cal_m <= {C3_DDR_SREF_CTRL_OUT[1], C2_DDR_SREF_CTRL_OUT[1], C0_DDR_SREF_CTRL_OUT[1]};
      cal_s <= cal_m;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Counter is parked at zero in the stable states and counts during transitions.
  always_comb begin
    err_set = 3'b000;
    tmo_hit = 3'b000;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = (cnt_q[i] == {TIMEOUT_W{1'b1}}) ? cnt_q[i] : cnt_q[i] + TIMEOUT_W'(1);
      tmo_hit[i] = (timeout_q != '0) && (cnt_q[i] == timeout_q);
      case (state_q[i])
        ST_ACTIVE: begin
          cnt_d[i] = '0;
          if (target_q[i]) state_d[i] = ST_ENTERING;
        end
        ST_ENTERING: begin
          if (ack_s[i]) begin
            state_d[i] = ST_IN_SREF;
          end else if (tmo_hit[i]) begin
            err_set[i] = 1'b1;
            state_d[i] = ST_EXITING;
            cnt_d[i]   = '0;
          end
        end
        ST_IN_SREF: begin
          cnt_d[i] = '0;
          if (!target_q[i]) state_d[i] = ST_EXITING;
        end
        default: begin
          if (!ack_s[i]) begin
            state_d[i] = ST_ACTIVE;
          end else if (tmo_hit[i]) begin
            err_set[i] = 1'b1;
            state_d[i] = ST_ACTIVE;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      req[i] = (state_q[i] == ST_ENTERING) || (state_q[i] == ST_IN_SREF);
  end

  assign C0_DDR_SREF_CTRL_IN = {7'h0, req[0]};
  assign C2_DDR_SREF_CTRL_IN = {7'h0, req[1]};
  assign C3_DDR_SREF_CTRL_IN = {7'h0, req[2]};

endmodule

// File: tb/tb_pr_sref_ctrl_slave.sv
// Directed bench for pr_sref_ctrl_slave: a cycle model of the channel rules
// checked every cycle, plus hand-computed register and handshake expectations.
module tb_pr_sref_ctrl_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  c0_in, c2_in, c3_in;
  logic [7:0]  c0_out = '0, c2_out = '0, c3_out = '0;

  always #5 clk = ~clk;

  pr_sref_ctrl_slave dut (
    .clk_250M(clk), .rst_250M(rst),
    .S_AXI_LITE_awaddr(awaddr), .S_AXI_LITE_awprot(awprot),
    .S_AXI_LITE_awvalid(awvalid), .S_AXI_LITE_awready(awready),
    .S_AXI_LITE_wdata(wdata), .S_AXI_LITE_wstrb(wstrb),
    .S_AXI_LITE_wvalid(wvalid), .S_AXI_LITE_wready(wready),
    .S_AXI_LITE_bresp(bresp), .S_AXI_LITE_bvalid(bvalid), .S_AXI_LITE_bready(bready),
    .S_AXI_LITE_araddr(araddr), .S_AXI_LITE_arprot(arprot),
    .S_AXI_LITE_arvalid(arvalid), .S_AXI_LITE_arready(arready),
    .S_AXI_LITE_rdata(rdata), .S_AXI_LITE_rresp(rresp),
    .S_AXI_LITE_rvalid(rvalid), .S_AXI_LITE_rready(rready),
    .C0_DDR_SREF_CTRL_IN(c0_in), .C2_DDR_SREF_CTRL_IN(c2_in), .C3_DDR_SREF_CTRL_IN(c3_in),
    .C0_DDR_SREF_CTRL_OUT(c0_out), .C2_DDR_SREF_CTRL_OUT(c2_out), .C3_DDR_SREF_CTRL_OUT(c3_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Channel phase: 0 idle, 1 requesting, 2 in self-refresh, 3 releasing.
  int        m_phase [3];
  int        m_wait  [3];
  bit [2:0]  m_tgt, m_err;
  bit [23:0] m_tmo;
  bit [2:0]  ack_hist [$];
  bit [2:0]  cal_hist [$];
  bit        m_bvalid;
  bit        m_aw_have, m_w_have;
  bit [11:0] m_aw_addr;
  bit [31:0] m_w_data;
  bit [3:0]  m_w_strb;
  bit        started = 0;

  function automatic bit [2:0] seen_ack();
    return ack_hist.size() >= 2 ? ack_hist[ack_hist.size()-2] : 3'b000;
  endfunction

  function automatic bit [2:0] seen_cal();
    return cal_hist.size() >= 2 ? cal_hist[cal_hist.size()-2] : 3'b000;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    for (int c = 0; c < 3; c++) s[2*c +: 2] = 2'(m_phase[c]);
    s[10:8]  = m_err;
    s[18:16] = seen_cal();
    return s;
  endfunction

  function automatic bit m_req(input int c);
    return m_phase[c] == 1 || m_phase[c] == 2;
  endfunction

  always @(posedge clk) begin
    bit [2:0]  ack, set_v;
    bit        clr, commit;
    bit [11:0] wa;
    bit [31:0] wd;
    bit [3:0]  ws;
    started = 1;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin m_phase[c] = 0; m_wait[c] = 0; end
      m_tgt = 0; m_err = 0; m_tmo = 24'd250000; m_bvalid = 0;
      m_aw_have = 0; m_w_have = 0;
      ack_hist.delete(); cal_hist.delete();
    end else begin
      ack = seen_ack();
      set_v = 0;
      for (int c = 0; c < 3; c++) begin
        bit expired;
        expired = (m_tmo != 0) && (m_wait[c] == int'(m_tmo));
        if (m_phase[c] == 0) begin
          if (m_tgt[c]) begin m_phase[c] = 1; m_wait[c] = 0; end
        end else if (m_phase[c] == 1) begin
          if (ack[c]) m_phase[c] = 2;
          else if (expired) begin set_v[c] = 1; m_phase[c] = 3; m_wait[c] = 0; end
          else m_wait[c]++;
        end else if (m_phase[c] == 2) begin
          if (!m_tgt[c]) begin m_phase[c] = 3; m_wait[c] = 0; end
        end else begin
          if (!ack[c]) m_phase[c] = 0;
          else if (expired) begin set_v[c] = 1; m_phase[c] = 0; end
          else m_wait[c]++;
        end
      end
      if (awvalid && awready) begin m_aw_have = 1; m_aw_addr = awaddr; end
      if (wvalid && wready) begin m_w_have = 1; m_w_data = wdata; m_w_strb = wstrb; end
      commit = m_aw_have && m_w_have;
      clr = 0;
      if (m_bvalid && bready) m_bvalid = 0;
      if (commit) begin
        wa = m_aw_addr; wd = m_w_data; ws = m_w_strb;
        m_aw_have = 0; m_w_have = 0; m_bvalid = 1;
        if (wa[11:2] == 0) begin
          if (ws[0]) m_tgt = wd[2:0];
          if (ws[1] && wd[8]) clr = 1;
        end else if (wa[11:2] == 2) begin
          for (int b = 0; b < 24; b++) if (ws[b/8]) m_tmo[b] = wd[b];
        end
      end
      m_err = (clr ? 3'b000 : m_err) | set_v;
      ack_hist.push_back({c3_out[0], c2_out[0], c0_out[0]});
      cal_hist.push_back({c3_out[1], c2_out[1], c0_out[1]});
      if (ack_hist.size() > 4) void'(ack_hist.pop_front());
      if (cal_hist.size() > 4) void'(cal_hist.pop_front());
    end
  end

  // Every-cycle comparison of the request pins and write response valid.
  always @(negedge clk) begin
    if (started) begin
      check("req_c0", c0_in, {7'h0, m_req(0)});
      check("req_c2", c2_in, {7'h0, m_req(1)});
      check("req_c3", c3_in, {7'h0, m_req(2)});
      check("bvalid", bvalid, m_bvalid);
    end
  end

  int b_pulses = 0;
  bit prev_b = 0, prev_c2 = 0, c2_fell = 0;
  always @(negedge clk) begin
    if (bvalid && !prev_b) b_pulses++;
    if (prev_c2 && !c2_in[0]) c2_fell = 1;
    prev_b = bvalid;
    prev_c2 = c2_in[0];
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0;
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while (!(aw_done && w_done) && n < 20) begin
      @(posedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0;
    lat = 0;
    while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
    if (!bvalid) check("b_wait_expired", 32'd0, 32'd1);
    resp = bresp;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output logic [31:0] exp_st);
    bit done = 0;
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 0;
    while (!done && n < 20) begin
      exp_st = m_status();
      @(posedge clk);
      if (arready) done = 1;
      @(negedge clk);
      n++;
    end
    arvalid = 0;
    if (!done) check("ar_wait_expired", 32'd0, 32'd1);
    check("rvalid_latency", rvalid, 1);
    data = rdata; resp = rresp; rready = 1;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [1:0] r;
    int l;
    axi_write(a, d, 4'hF, r, l);
    check("wr_bresp", r, 2'b00);
    check("wr_b_latency", l, 0);
  endtask

  task automatic rd_status(output logic [31:0] st);
    logic [31:0] e;
    logic [1:0]  r;
    axi_read(12'h004, st, r, e);
    check("status_vs_model", st, e);
    check("status_rresp", r, 2'b00);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d, st, e, d2, e2;
    logic [1:0]  r, r2;
    int          l, pulses0;

    repeat (3) @(negedge clk);
    check("awready_in_reset", awready, 0);
    check("wready_in_reset", wready, 0);
    check("arready_in_reset", arready, 0);
    check("rvalid_in_reset", rvalid, 0);
    check("sref_in_reset", {c0_in, c2_in, c3_in}, 0);
    rst = 0;
    c0_out = 8'h02; c2_out = 8'h02;
    @(posedge clk); #1;
    check("ready_after_reset", {awready, wready, arready}, 3'b111);

    axi_read(12'h00C, d, r, e);
    check("id_value", d, 32'h53524546);
    check("id_rresp", r, 2'b00);
    axi_read(12'h008, d, r, e);
    check("timeout_default", d, 32'd250000);

    // C0 entry: request one cycle after the write response, ack then lands in IN_SREF.
    wr(12'h000, 32'h1);
    check("c0_req_after_commit", c0_in, 8'h01);
    c0_out = 8'h03;
    repeat (3) @(negedge clk);
    rd_status(st);
    check("c0_in_sref", st[1:0], 2'd2);
    check("calib_bits", st[18:16], 3'b011);

    wr(12'h000, 32'h0);
    check("c0_req_dropped", c0_in, 8'h00);
    rd_status(st);
    check("c0_exiting", st[1:0], 2'd3);
    c0_out = 8'h02;
    repeat (4) @(negedge clk);
    rd_status(st);
    check("c0_active", st[1:0], 2'd0);

    // C2 entry timeout with ack stuck low.
    wr(12'h008, 32'd16);
    wr(12'h000, 32'h2);
    repeat (25) @(negedge clk);
    rd_status(st);
    check("c2_timeout_err", st[10:8], 3'b010);
    check("c2_passed_exiting", c2_fell, 1);
    wr(12'h000, 32'h0);
    repeat (40) @(negedge clk);
    wr(12'h000, 32'h100);
    rd_status(st);
    check("err_cleared", st, 32'h0003_0000);

    // AW five cycles ahead of W, B held off four cycles.
    pulses0 = b_pulses;
    @(negedge clk);
    awaddr = 12'h008; awvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("awready_held_low", awready, 0);
      check("no_early_b", bvalid, 0);
      if (i < 4) @(negedge clk);
    end
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      check("bvalid_held", bvalid, 1);
      check("awready_during_b", awready, 0);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("bvalid_done", bvalid, 0);
    check("awready_after_b", awready, 1);
    check("single_b_pulse", b_pulses - pulses0, 1);

    axi_write(12'h008, 32'hFFFF_FFAB, 4'b0001, r, l);
    axi_read(12'h008, d, r, e);
    check("timeout_byte_strobe", d, 32'h0000_12AB);

    axi_write(12'h040, 32'hDEAD_BEEF, 4'hF, r, l);
    check("unmapped_bresp", r, 2'b10);
    axi_read(12'h040, d, r, e);
    check("unmapped_rresp", r, 2'b10);
    check("unmapped_rdata", d, 32'h0);

    // Read issued on the commit edge sees the old contents.
    fork
      axi_write(12'h008, 32'h55, 4'hF, r2, l);
      axi_read(12'h008, d2, r, e2);
    join
    check("read_pre_write", d2, 32'h0000_12AB);
    axi_read(12'h008, d, r, e);
    check("read_post_write", d, 32'h55);

    wr(12'h000, 32'h1);
    axi_read(12'h000, d, r, e);
    check("ctrl_readback", d, 32'h1);
    repeat (2) @(negedge clk);
    check("c0_entering_req", c0_in, 8'h01);
    rst = 1;
    @(negedge clk);
    check("reset_drops_req", {c0_in, c2_in, c3_in}, 24'h0);
    check("reset_awready", awready, 0);
    @(negedge clk);
    rst = 0;
    axi_read(12'h000, d, r, e);
    check("ctrl_after_reset", d, 32'h0);
    axi_read(12'h008, d, r, e);
    check("timeout_after_reset", d, 32'd250000);
    rd_status(st);
    check("status_after_reset", st, 32'h0003_0000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
